// File: rtl/mem_responder_if.sv
// Request/response channel pair between a memory client and the mem_responder.
// The master drives requests and sinks responses; the slave is the memory side.
interface mem_responder_if;
    logic        req_vld;
    logic        req_rdy;
    logic [31:0] req_addr;
    logic        req_we;
    logic [3:0]  req_be;
    logic [31:0] req_wdat;
    logic        rsp_vld;
    logic        rsp_rdy;
    logic [31:0] rsp_dat;

    modport master (
        output req_vld, req_addr, req_we, req_be, req_wdat, rsp_rdy,
        input  req_rdy, rsp_vld, rsp_dat
    );

    modport slave (
        input  req_vld, req_addr, req_we, req_be, req_wdat, rsp_rdy,
        output req_rdy, rsp_vld, rsp_dat
    );
endinterface

// File: rtl/mem_responder.sv
// Word RAM answering requests in order after LATENCY cycles, up to MAX_OUTSTANDING in flight;
// req_rdy comes from registered occupancy only, so a full FIFO frees a slot the cycle after a pop.
module mem_responder #(
    parameter int          WORDS           = 4096,
    parameter logic [31:0] BASE_ADDR       = 32'h8000_0000,
    parameter int          LATENCY         = 2,
    parameter int          MAX_OUTSTANDING = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    mem_responder_if.slave  io_mem
);
    localparam int              AW        = $clog2(WORDS);
    localparam int              PW        = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int              CW        = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [3:0]      CNT_INIT  = 4'(LATENCY - 1);
    localparam logic [PW-1:0]   PTR_LAST  = PW'(MAX_OUTSTANDING - 1);
    localparam logic [CW-1:0]   CNT_FULL  = CW'(MAX_OUTSTANDING);

    logic [31:0]   r_ram  [WORDS];
    logic [31:0]   r_data [MAX_OUTSTANDING];
    logic [3:0]    r_cnt  [MAX_OUTSTANDING];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic          r_live;

    logic [29:0]                w_woff;
    logic                       w_inrange;
    logic [AW-1:0]              w_idx;
    logic [31:0]                w_rdat;
    logic                       w_push;
    logic                       w_pop;
    logic [MAX_OUTSTANDING-1:0] w_occ;

    // Word-granular subtract; addresses below the base wrap to a huge offset.
    assign w_woff    = io_mem.req_addr[31:2] - BASE_ADDR[31:2];
    assign w_inrange = (w_woff >> AW) == '0;
    assign w_idx     = w_woff[AW-1:0];
    assign w_rdat    = (w_inrange && !io_mem.req_we) ? r_ram[w_idx] : 32'h0;

    assign io_mem.req_rdy = r_live && (r_count < CNT_FULL);
    assign io_mem.rsp_vld = (r_count != '0) && (r_cnt[r_head] == 4'd0);
    assign io_mem.rsp_dat = r_data[r_head];

    assign w_push = io_mem.req_vld && io_mem.req_rdy;
    assign w_pop  = io_mem.rsp_vld && io_mem.rsp_rdy;

    always_comb begin
        w_occ = '0;
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            w_occ[i] = ((i >= int'(r_head)) ? (i - int'(r_head))
                                            : (i + MAX_OUTSTANDING - int'(r_head))) < int'(r_count);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_live  <= 1'b0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                r_data[i] <= 32'h0;
                r_cnt[i]  <= 4'd0;
            end
        end else begin
            r_live <= 1'b1;
            // Countdown runs for every occupied entry even while the head is stalled.
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                if (w_occ[i] && (r_cnt[i] != 4'd0)) begin
                    r_cnt[i] <= r_cnt[i] - 4'd1;
                end
            end
            if (w_push) begin
                r_data[r_tail] <= w_rdat;
                r_cnt[r_tail]  <= CNT_INIT;
                r_tail         <= (r_tail == PTR_LAST) ? '0 : r_tail + PW'(1);
            end
            if (w_pop) begin
                r_head <= (r_head == PTR_LAST) ? '0 : r_head + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // RAM contents survive reset, so accepted writes persist across it.
    always_ff @(posedge i_clk) begin
        if (w_push && io_mem.req_we && w_inrange) begin
            for (int b = 0; b < 4; b++) begin
                if (io_mem.req_be[b]) begin
                    r_ram[w_idx][8*b +: 8] <= io_mem.req_wdat[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: vector table plus hand sequences, all responses checked
// through an in-order scoreboard filled at request acceptance.
module tb_mem_responder;
    localparam int          L     = 2;
    localparam int          M     = 4;
    localparam int          WORDS = 4096;
    localparam logic [31:0] BASE  = 32'h8000_0000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_responder_if io();

    mem_responder #(
        .WORDS(WORDS), .BASE_ADDR(BASE), .LATENCY(L), .MAX_OUTSTANDING(M)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .io_mem (io)
    );

    typedef struct {
        logic [31:0] dat;
        int          acc;
        bit          tight;
    } sb_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    sb_t         sb[$];
    logic [31:0] model [int];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          acc_count = 0;
    int          rsp_count = 0;
    logic [31:0] drv_exp = 32'h0;
    bit          drv_tight = 1'b0;
    logic [31:0] held;
    bit          head_seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mexp(input logic [31:0] a, input logic we);
        logic [31:0] off;
        off = a - BASE;
        if (we || off >= 32'(WORDS * 4)) return 32'h0;
        return model.exists(int'(off >> 2)) ? model[int'(off >> 2)] : 32'h0;
    endfunction

    // Monitor: accepted requests go into the scoreboard, responses are compared in order.
    always @(negedge clk) begin
        if (!rst_n) begin
            head_seen = 1'b0;
        end else begin
            if (io.req_vld && io.req_rdy) begin
                logic [31:0] off;
                logic [31:0] w;
                sb.push_back('{drv_exp, cyc + 1, drv_tight});
                acc_count++;
                off = io.req_addr - BASE;
                if (io.req_we && off < 32'(WORDS * 4)) begin
                    w = model.exists(int'(off >> 2)) ? model[int'(off >> 2)] : 32'h0;
                    for (int b = 0; b < 4; b++)
                        if (io.req_be[b]) w[8*b +: 8] = io.req_wdat[8*b +: 8];
                    model[int'(off >> 2)] = w;
                end
            end
            if (io.rsp_vld) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got data %h with no request outstanding (cycle %0d)",
                             io.rsp_dat, cyc);
                end else begin
                    if (!head_seen) begin
                        head_seen = 1'b1;
                        held = io.rsp_dat;
                        if (sb[0].tight) chk("latency", 32'(cyc - sb[0].acc), 32'(L - 1));
                    end else begin
                        chk("hold_stable", io.rsp_dat, held);
                    end
                    if (io.rsp_rdy) begin
                        chk("rsp_data", io.rsp_dat, sb[0].dat);
                        void'(sb.pop_front());
                        head_seen = 1'b0;
                        rsp_count++;
                    end
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the acceptance edge with req_vld still high.
    task automatic send(input logic [31:0] a, input logic we, input logic [3:0] be,
                        input logic [31:0] wd, input logic [31:0] exp, input bit tight,
                        output int waited);
        bit done;
        io.req_addr = a;
        io.req_we   = we;
        io.req_be   = be;
        io.req_wdat = wd;
        drv_exp     = exp;
        drv_tight   = tight;
        io.req_vld  = 1'b1;
        waited      = 0;
        done        = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (io.req_rdy) begin
                done = 1'b1;
            end else begin
                waited++;
                if (waited >= 50) begin
                    checks++;
                    errors++;
                    $display("FAIL req_timeout: req_rdy 0 for %0d cycles, required 1", waited);
                    done = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || io.rsp_vld) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", 32'(sb.size()), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    vec_t vt[15];
    int   w;
    int   a0;
    int   r0;

    initial begin
        vt[0]  = '{32'h8000_0010, 1'b1, 4'b1111, 32'h1234_5678, 32'h0};
        vt[1]  = '{32'h8000_0010, 1'b0, 4'b0000, 32'h0,         32'h1234_5678};
        vt[2]  = '{32'h8000_0010, 1'b1, 4'b0010, 32'hAABB_CCDD, 32'h0};
        vt[3]  = '{32'h8000_0010, 1'b0, 4'b0000, 32'h0,         32'h1234_CC78};
        vt[4]  = '{32'h8000_0012, 1'b0, 4'b0000, 32'h0,         32'h1234_CC78};
        vt[5]  = '{32'h8000_0000, 1'b1, 4'b1111, 32'hCAFE_F00D, 32'h0};
        vt[6]  = '{32'h7FFF_FFFC, 1'b0, 4'b0000, 32'h0,         32'h0};
        vt[7]  = '{32'h8000_4000, 1'b0, 4'b0000, 32'h0,         32'h0};
        vt[8]  = '{32'h8000_4000, 1'b1, 4'b1111, 32'hDEAD_BEEF, 32'h0};
        vt[9]  = '{32'h8000_0000, 1'b0, 4'b0000, 32'h0,         32'hCAFE_F00D};
        vt[10] = '{32'h8000_3FFC, 1'b1, 4'b1111, 32'h1122_3344, 32'h0};
        vt[11] = '{32'h8000_3FFC, 1'b0, 4'b0000, 32'h0,         32'h1122_3344};
        vt[12] = '{32'hFFFF_FFFC, 1'b0, 4'b0000, 32'h0,         32'h0};
        vt[13] = '{32'h8000_0010, 1'b1, 4'b1001, 32'h0102_0304, 32'h0};
        vt[14] = '{32'h8000_0010, 1'b0, 4'b0000, 32'h0,         32'h0134_CC04};

        io.req_vld  = 1'b1;
        io.req_addr = BASE;
        io.req_we   = 1'b0;
        io.req_be   = 4'b0;
        io.req_wdat = 32'h0;
        io.rsp_rdy  = 1'b0;

        // Reset held with a request pending.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_rdy", 32'(io.req_rdy), 32'h0);
        chk("rst_rsp_vld", 32'(io.rsp_vld), 32'h0);
        chk("rst_rsp_dat", io.rsp_dat, 32'h0);
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        io.req_vld = 1'b0;
        @(posedge clk);
        #1;
        chk("rdy_after_rst", 32'(io.req_rdy), 32'h1);

        // Vector table, back-to-back, response ready held high.
        io.rsp_rdy = 1'b1;
        for (int i = 0; i < 15; i++) begin
            send(vt[i].addr, vt[i].we, vt[i].be, vt[i].wd, vt[i].exp, 1'b1, w);
        end
        io.req_vld = 1'b0;
        drain();

        // Streaming: preload words 0..15, then 16 back-to-back reads.
        r0 = rsp_count;
        for (int i = 0; i < 16; i++) begin
            send(BASE + 32'(4 * i), 1'b1, 4'hF, 32'h1000_0000 + 32'(i * 32'h0101), 32'h0, 1'b1, w);
        end
        for (int i = 0; i < 16; i++) begin
            send(BASE + 32'(4 * i), 1'b0, 4'h0, 32'h0, mexp(BASE + 32'(4 * i), 1'b0), 1'b1, w);
            chk("stream_no_stall", 32'(w), 32'h0);
        end
        io.req_vld = 1'b0;
        drain();
        chk("stream_count", 32'(rsp_count - r0), 32'd32);

        // Full FIFO with response side stalled.
        io.rsp_rdy = 1'b0;
        a0 = acc_count;
        r0 = rsp_count;
        for (int i = 0; i < 4; i++) begin
            send(BASE + 32'(4 * i), 1'b0, 4'h0, 32'h0, mexp(BASE + 32'(4 * i), 1'b0), 1'b0, w);
        end
        io.req_addr = BASE + 32'd16;
        io.req_we   = 1'b0;
        drv_exp     = mexp(BASE + 32'd16, 1'b0);
        drv_tight   = 1'b0;
        io.req_vld  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("full_rdy_low", 32'(io.req_rdy), 32'h0);
            @(posedge clk);
            #1;
        end
        chk("full_accepted", 32'(acc_count - a0), 32'd4);
        io.rsp_rdy = 1'b1;
        @(negedge clk);
        chk("full_rdy_during_pop", 32'(io.req_rdy), 32'h0);
        @(posedge clk);
        #1;
        io.rsp_rdy = 1'b0;
        @(negedge clk);
        chk("rdy_after_pop", 32'(io.req_rdy), 32'h1);
        chk("one_resp", 32'(rsp_count - r0), 32'd1);
        @(posedge clk);
        #1;
        io.rsp_rdy = 1'b1;
        send(BASE + 32'd20, 1'b0, 4'h0, 32'h0, mexp(BASE + 32'd20, 1'b0), 1'b0, w);
        io.req_vld = 1'b0;
        drain();
        chk("full_total", 32'(rsp_count - r0), 32'd6);

        // Reset with three requests in flight, one of them a write to word 5.
        io.rsp_rdy = 1'b0;
        send(BASE + 32'd4,  1'b0, 4'h0, 32'h0,         mexp(BASE + 32'd4, 1'b0), 1'b0, w);
        send(BASE + 32'd20, 1'b1, 4'hF, 32'h5555_AAAA, 32'h0,                    1'b0, w);
        send(BASE + 32'd8,  1'b0, 4'h0, 32'h0,         mexp(BASE + 32'd8, 1'b0), 1'b0, w);
        io.req_vld = 1'b0;
        r0 = rsp_count;
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("midrst_rsp_vld", 32'(io.rsp_vld), 32'h0);
        chk("midrst_req_rdy", 32'(io.req_rdy), 32'h0);
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        io.rsp_rdy = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("no_rsp_after_rst", 32'(rsp_count - r0), 32'h0);
        send(BASE + 32'd20, 1'b0, 4'h0, 32'h0, 32'h5555_AAAA, 1'b1, w);
        io.req_vld = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
